// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: widths, controller states and GF(2^8) helpers
// used by the round-key stage.
package aes_pkg;
   localparam int unsigned KEY_W  = 256;
   localparam int unsigned RK_W   = 128;
   localparam int unsigned NUM_RK = 15;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse as x^254 (square-and-multiply), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [4:0] r);
      logic [7:0] rc;
      rc = 8'h01;
      for (int unsigned i = 1; i < 10; i++) begin
         if (i < 32'(r)) rc = xtime(rc);
      end
      return rc;
   endfunction
endpackage

// File: rtl/round_key.sv
// One AES-256 expansion step: derives the next eight key words from the previous
// eight (k) for round index r.
module round_key
   import aes_pkg::*;
(
   input  logic [KEY_W-1:0] k,
   input  logic [4:0]       r,
   output logic [KEY_W-1:0] result
);
   logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
   logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;

   always_comb begin
      {w0, w1, w2, w3, w4, w5, w6, w7} = k;
      n0 = w0 ^ sub_word({w7[23:0], w7[31:24]}) ^ {rcon(r), 24'h000000};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      n4 = w4 ^ sub_word(n3);
      n5 = w5 ^ n4;
      n6 = w6 ^ n5;
      n7 = w7 ^ n6;
      result = {n0, n1, n2, n3, n4, n5, n6, n7};
   end
endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-256 key expansion: one round_key step per cycle into a flat
// 15-entry round-key register file, readable by index at any time.
module key_schedule_seq
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_v_i,
   input  logic [KEY_W-1:0]  key_i,
   output logic              key_ready_o,
   input  logic [3:0]        rk_addr_i,
   output logic [RK_W-1:0]   rk_o,
   output logic              keys_valid_o
);
   ks_state_e        state_q, state_d;
   logic [2:0]       r_cnt_q, r_cnt_d;
   logic [KEY_W-1:0] cur_q, cur_d;
   logic [RK_W-1:0]  rk_q [NUM_RK];
   logic [RK_W-1:0]  rk_d [NUM_RK];
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic [KEY_W-1:0] res;
   logic             accept;

   round_key u_round_key (
      .k      (cur_q),
      .r      ({2'b00, r_cnt_q}),
      .result (res)
   );

   assign key_ready_o  = rst_n & ready_q;
   assign keys_valid_o = valid_q;
   assign rk_o         = (32'(rk_addr_i) < NUM_RK) ? rk_q[rk_addr_i] : '0;
   assign accept       = key_v_i & key_ready_o;

   always_comb begin
      state_d = state_q;
      r_cnt_d = r_cnt_q;
      cur_d   = cur_q;
      rk_d    = rk_q;
      valid_d = valid_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               rk_d[0] = key_i[KEY_W-1:RK_W];
               rk_d[1] = key_i[RK_W-1:0];
               cur_d   = key_i;
               r_cnt_d = 3'd1;
               valid_d = 1'b0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            // Pair decode: entry 2r takes the upper half, 2r+1 the lower; 15 never exists.
            for (int unsigned i = 0; i < NUM_RK; i++) begin
               if (4'(i) == {r_cnt_q, 1'b0})      rk_d[i] = res[KEY_W-1:RK_W];
               else if (4'(i) == {r_cnt_q, 1'b1}) rk_d[i] = res[RK_W-1:0];
            end
            cur_d   = res;
            r_cnt_d = r_cnt_q + 3'd1;
            if (r_cnt_q == 3'd7) begin
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d != EXPAND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_cnt_q <= '0;
         cur_q   <= '0;
         rk_q    <= '{default: '0};
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         r_cnt_q <= r_cnt_d;
         cur_q   <= cur_d;
         rk_q    <= rk_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end
endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 vectors plus random keys against a
// word-level AES-256 expansion model with a search-built S-box.
`timescale 1ns/1ps
module tb_key_schedule_seq;
   logic         clk;
   logic         rst_n;
   logic         key_v_i;
   logic [255:0] key_i;
   logic         key_ready_o;
   logic [3:0]   rk_addr_i;
   logic [127:0] rk_o;
   logic         keys_valid_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] exp_rk [15];

   localparam logic [255:0] FIPS_KEY =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   key_schedule_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_v_i      (key_v_i),
      .key_i        (key_i),
      .key_ready_o  (key_ready_o),
      .rk_addr_i    (rk_addr_i),
      .rk_o         (rk_o),
      .keys_valid_o (keys_valid_o)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         logic [7:0] s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (poly_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
         sbox_tab[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] tb_subword(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   // Standard FIPS-197 word recurrence for Nk=8, 60 words.
   task automatic model_expand(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc [7];
      rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
      for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         tmp = w[i-1];
         if (i % 8 == 0)
            tmp = tb_subword({tmp[23:0], tmp[31:24]}) ^ {rc[i/8 - 1], 24'h0};
         else if (i % 8 == 4)
            tmp = tb_subword(tmp);
         w[i] = w[i-8] ^ tmp;
      end
      for (int j = 0; j < 15; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_rk(input int a, output logic [127:0] v);
      rk_addr_i = 4'(a);
      #1;
      v = rk_o;
   endtask

   task automatic sweep(input string tag, input logic [255:0] key);
      logic [127:0] v;
      model_expand(key);
      for (int a = 0; a < 15; a++) begin
         read_rk(a, v);
         check($sformatf("%s_rk%0d", tag, a), 256'(v), 256'(exp_rk[a]));
      end
      read_rk(15, v);
      check({tag, "_rk15"}, 256'(v), 256'(0));
   endtask

   task automatic sweep_zero(input string tag);
      logic [127:0] v;
      for (int a = 0; a < 16; a++) begin
         read_rk(a, v);
         check($sformatf("%s_zero%0d", tag, a), 256'(v), 256'(0));
      end
   endtask

   task automatic accept_key(input string tag, input logic [255:0] k);
      check({tag, "_ready_pre"}, 256'(key_ready_o), 256'(1));
      key_v_i = 1'b1;
      key_i   = k;
      tick();
      key_v_i = 1'b0;
   endtask

   // Called just after the accept edge; counts edges until keys_valid_o rises.
   task automatic wait_done(input string tag);
      int cnt;
      cnt = 0;
      check({tag, "_valid_drop"}, 256'(keys_valid_o), 256'(0));
      check({tag, "_busy"}, 256'(key_ready_o), 256'(0));
      while (!keys_valid_o && cnt < 20) begin
         tick();
         cnt++;
         if (!keys_valid_o)
            check({tag, "_busy_mid"}, 256'(key_ready_o), 256'(0));
      end
      check({tag, "_latency"}, 256'(cnt), 256'(7));
      check({tag, "_ready_post"}, 256'(key_ready_o), 256'(1));
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] k2;
      logic [255:0] kr;
      logic [127:0] v;
      build_sbox();
      rst_n     = 1'b0;
      key_v_i   = 1'b0;
      key_i     = '0;
      rk_addr_i = '0;

      // Reset held three cycles
      repeat (3) begin
         tick();
         check("rst_valid", 256'(keys_valid_o), 256'(0));
         check("rst_ready", 256'(key_ready_o), 256'(0));
      end
      sweep_zero("rst");
      rst_n = 1'b1;
      #1;
      check("rel_ready", 256'(key_ready_o), 256'(1));
      tick();
      check("idle_ready", 256'(key_ready_o), 256'(1));
      check("idle_valid", 256'(keys_valid_o), 256'(0));

      // FIPS-197 AES-256 key
      accept_key("fips", FIPS_KEY);
      wait_done("fips");
      read_rk(0, v);  check("fips_c0",  256'(v), 256'(128'h603deb1015ca71be2b73aef0857d7781));
      read_rk(2, v);  check("fips_c2",  256'(v), 256'(128'h9ba354118e6925afa51a8b5f2067fcde));
      read_rk(3, v);  check("fips_c3",  256'(v), 256'(128'ha8b09c1a93d194cdbe49846eb75d5b9a));
      read_rk(14, v); check("fips_c14", 256'(v), 256'(128'hfe4890d1e6188d0b046df344706c631e));
      sweep("fips", FIPS_KEY);

      // Key held valid through EXPAND is ignored, then taken once ready returns
      k2 = rand_key();
      accept_key("hold", FIPS_KEY);
      key_v_i = 1'b1;
      key_i   = k2;
      wait_done("hold");
      sweep("hold", FIPS_KEY);
      tick();
      key_v_i = 1'b0;
      check("hold2_valid_drop", 256'(keys_valid_o), 256'(0));
      read_rk(1, v); check("hold2_rk1", 256'(v), 256'(k2[127:0]));
      wait_done("hold2");
      sweep("hold2", k2);

      // Back-to-back load from DONE
      kr = {32{8'h64}};
      accept_key("b2b", kr);
      read_rk(0, v); check("b2b_rk0", 256'(v), 256'(kr[255:128]));
      read_rk(1, v); check("b2b_rk1", 256'(v), 256'(kr[127:0]));
      wait_done("b2b");
      sweep("b2b", kr);

      // Reset in the middle of expansion
      accept_key("abort", rand_key());
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("abort_valid", 256'(keys_valid_o), 256'(0));
      check("abort_ready", 256'(key_ready_o), 256'(0));
      sweep_zero("abort");
      rst_n = 1'b1;
      tick();
      kr = rand_key();
      accept_key("reload", kr);
      wait_done("reload");
      sweep("reload", kr);

      // Random keys
      for (int n = 0; n < 4; n++) begin
         kr = rand_key();
         accept_key($sformatf("rnd%0d", n), kr);
         wait_done($sformatf("rnd%0d", n));
         sweep($sformatf("rnd%0d", n), kr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
